// File: rtl/hs32_div.sv
// hs32 iterative divider: radix-2 non-restoring, one quotient bit per clock.
// Handshaked request/result ports; NZCV flags laid out like the ALU's.
module hs32_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  input  logic             fwe_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic [3:0]       flags_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+1:0] p_q, p_d;
  logic [WIDTH-1:0] qw_q, qw_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             fwe_q, fwe_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div0, sovf;
  logic [WIDTH+1:0] sh, dx, step;
  logic [WIDTH-1:0] rem_raw, q_res, r_res;
  logic [3:0]       flags_new;

  assign ready_o = (state_q == IDLE) && !reset;
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q == CALC) || (state_q == FIX);
  assign q_o     = q_out_q;
  assign r_o     = r_out_q;
  assign flags_o = flags_q;

  assign accept = valid_i && ready_o;
  assign a_neg  = signed_i & a_i[WIDTH-1];
  assign b_neg  = signed_i & b_i[WIDTH-1];
  assign a_abs  = a_neg ? -a_i : a_i;
  assign b_abs  = b_neg ? -b_i : b_i;
  assign div0   = (b_i == '0);
  assign sovf   = signed_i && (a_i == MIN_V) && (b_i == '1);

  // Remainder carries two guard bits so 2p+1 never overflows before the add/sub.
  assign sh   = {p_q[WIDTH:0], qw_q[WIDTH-1]};
  assign dx   = {2'b00, d_q};
  assign step = p_q[WIDTH+1] ? (sh + dx) : (sh - dx);

  assign rem_raw = p_q[WIDTH+1] ? (p_q[WIDTH-1:0] + d_q)
                                : p_q[WIDTH-1:0];
  assign q_res   = qneg_q ? -qw_q : qw_q;
  assign r_res   = rneg_q ? -rem_raw : rem_raw;

  assign flags_new = {q_out_q[WIDTH-1], (q_out_q == '0), 1'b0, ovf_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qw_d    = qw_q;
    d_d     = d_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    fwe_d   = fwe_q;
    ovf_d   = ovf_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          fwe_d = fwe_i;
          cnt_d = '0;
          if (div0 || sovf) begin
            // Preload the final answer and let FIX publish it unchanged.
            qw_d    = div0 ? '1 : MIN_V;
            p_d     = div0 ? {2'b00, a_i} : '0;
            d_d     = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            ovf_d   = 1'b1;
            state_d = FIX;
          end else begin
            qw_d    = a_abs;
            p_d     = '0;
            d_d     = b_abs;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = step;
        qw_d  = {qw_q[WIDTH-2:0], ~step[WIDTH+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        q_out_d = q_res;
        r_out_d = r_res;
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) begin
          if (fwe_q) flags_d = flags_new;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      qw_q    <= '0;
      d_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      fwe_q   <= 1'b0;
      ovf_q   <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qw_q    <= qw_d;
      d_q     <= d_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      fwe_q   <= fwe_d;
      ovf_q   <= ovf_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_hs32_div.sv
// hs32_div bench: directed cases plus random operands
// against a plain-arithmetic divide model.
module tb_hs32_div;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        signed_i = 1'b0;
  logic        fwe_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] q_o;
  logic [31:0] r_o;
  logic [3:0]  flags_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  logic [3:0] flags_exp = 4'b0000;

  always #5 clk = ~clk;

  hs32_div #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .signed_i (signed_i),
    .fwe_i    (fwe_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .q_o      (q_o),
    .r_o      (r_o),
    .flags_o  (flags_o),
    .busy_o   (busy_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input bit sgn,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output bit v);
    int sa, sb;
    sa = a;
    sb = b;
    v = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      v = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
      v = 1'b1;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input bit sgn, input bit fwe, input int stall);
    logic [31:0] qe, re;
    bit v;
    int lat, w;
    ref_div(a, b, sgn, qe, re, v);
    w = 0;
    while (!ready_o && w < 5) begin
      step();
      w++;
    end
    chk("ready_before", ready_o, 1);
    a_i = a;
    b_i = b;
    signed_i = sgn;
    fwe_i = fwe;
    ready_i = 1'b0;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    chk("busy_after_accept", busy_o, 1);
    chk("ready_low_busy", ready_o, 0);
    lat = 0;
    while (!valid_o && lat < 100) begin
      step();
      lat++;
    end
    chk("latency", lat, v ? 1 : 33);
    chk("quot", q_o, qe);
    chk("rem", r_o, re);
    for (int i = 0; i < stall; i++) begin
      valid_i = 1'b1;
      a_i = $urandom;
      b_i = $urandom;
      step();
      chk("stall_valid", valid_o, 1);
      chk("stall_ready", ready_o, 0);
      chk("stall_q", q_o, qe);
      chk("stall_r", r_o, re);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    if (fwe) flags_exp = {qe[31], qe == 32'd0, 1'b0, v};
    chk("valid_drop", valid_o, 0);
    chk("ready_after_retire", ready_o, 1);
    chk("q_hold", q_o, qe);
    chk("flags", flags_o, flags_exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int mode;
    repeat (3) step();
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_q", q_o, 0);
    chk("rst_r", r_o, 0);
    chk("rst_flags", flags_o, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", ready_o, 1);

    run(32'd100, 32'd7, 1'b0, 1'b1, 0);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
    run(32'h1234_5678, 32'd0, 1'b0, 1'b1, 0);
    run(32'd17, 32'd5, 1'b0, 1'b1, 0);
    run(32'h1234_5678, 32'd0, 1'b1, 1'b0, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    run(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, 1'b1, 10);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 2);

    a_i = 32'd1000;
    b_i = 32'd7;
    signed_i = 1'b0;
    fwe_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (15) step();
    reset = 1'b1;
    step();
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_flags", flags_o, 0);
    chk("midrst_ready", ready_o, 0);
    reset = 1'b0;
    #1;
    chk("midrst_ready_rel", ready_o, 1);
    flags_exp = 4'b0000;
    run(32'd5, 32'd5, 1'b0, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 16);
        3: rb = -$urandom_range(1, 16);
        4: ra = $urandom_range(0, 40);
        default: ;
      endcase
      run(ra, rb, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
